// File: rtl/sha256_stream_core.sv
// sha256_stream_core
//   Byte-streaming SHA-256 engine. Message bytes arrive one per valid cycle
//   (big-endian within each 32-bit word). FIPS 180-4 padding is applied
//   internally. Each 512-bit block takes LOAD (1) + ROUND (64) + UPDATE (1)
//   cycles. The digest is registered on the final UPDATE edge, together with
//   a sticky done flag.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse, begins a new message (wins over data_valid)
//   data_in     message byte
//   data_valid  data_in valid this cycle (accepted only while receiving)
//   data_last   marks data_in as the final message byte
//   hash_out    digest {H0..H7}, H0 in [255:224]
//   done        digest valid, held until start or rst
module sha256_stream_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   data_in,
    input  logic         data_valid,
    input  logic         data_last,
    output logic [255:0] hash_out,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_LOAD, S_ROUND, S_UPDATE, S_PAD, S_FINAL
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    buf_q [64];
    logic [5:0]    byte_idx_q;
    logic [63:0]   bitlen_q;
    logic [31:0]   h_q   [8];
    logic [31:0]   wv_q  [8];   // a..h
    logic [31:0]   w_q   [16];  // w_q[k] = W[t+k] during round t
    logic [5:0]    round_q;
    logic          pad_pend_q;  // message ended on a block boundary
    logic          len_pend_q;  // length did not fit, a zero+length block follows
    logic          final_q;     // block being compressed is the last one
    logic [255:0]  hash_q;
    logic          done_q;

    // control strobes
    logic byte_wr, load_en, round_en, upd_en, pad_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RECV: begin
                if (data_valid) begin
                    if (byte_idx_q == 6'd63) state_d = S_LOAD;
                    else if (data_last)      state_d = S_PAD;
                end
            end
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (round_q == 6'd63) state_d = S_UPDATE;
            S_UPDATE: begin
                if (final_q)                       state_d = S_FINAL;
                else if (pad_pend_q || len_pend_q) state_d = S_PAD;
                else                               state_d = S_RECV;
            end
            S_PAD:   state_d = S_LOAD;
            S_FINAL: state_d = S_FINAL;
            default: state_d = S_IDLE;
        endcase
        if (start) state_d = S_RECV;
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        byte_wr  = 1'b0;
        load_en  = 1'b0;
        round_en = 1'b0;
        upd_en   = 1'b0;
        pad_en   = 1'b0;
        case (state_q)
            S_RECV:   byte_wr  = data_valid;
            S_LOAD:   load_en  = 1'b1;
            S_ROUND:  round_en = 1'b1;
            S_UPDATE: upd_en   = 1'b1;
            S_PAD:    pad_en   = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Round function and schedule
    // ------------------------------------------------------------------
    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_nx;
    logic [31:0] h_sum [8];
    logic        len_fits;

    always_comb begin
        big_s1 = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
        ch     = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
        t1     = wv_q[7] + big_s1 + ch + K[round_q] + w_q[0];
        big_s0 = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
        maj    = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
        t2     = big_s0 + maj;
        // W[t+16]; computed every round, the last 16 are simply unused
        w_nx   = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
               + w_q[9]
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
               + w_q[0];
        for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + wv_q[i];
        // the 0x80 at byte_idx still leaves bytes 56..63 free for the length
        len_fits = (byte_idx_q <= 6'd55);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) buf_q[i] <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= 32'h0;
                wv_q[i] <= 32'h0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
            byte_idx_q <= 6'd0;
            bitlen_q   <= 64'd0;
            round_q    <= 6'd0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
            final_q    <= 1'b0;
            hash_q     <= 256'h0;
            done_q     <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
            byte_idx_q <= 6'd0;
            bitlen_q   <= 64'd0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
            final_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (byte_wr) begin
                buf_q[byte_idx_q] <= data_in;
                byte_idx_q        <= byte_idx_q + 6'd1;
                bitlen_q          <= bitlen_q + 64'd8;
                if (byte_idx_q == 6'd63) pad_pend_q <= data_last;
            end

            if (pad_en) begin
                for (int i = 0; i < 64; i++) begin
                    if (len_pend_q)                 buf_q[i] <= 8'h00;
                    else if (6'(i) == byte_idx_q)   buf_q[i] <= 8'h80;
                    else if (6'(i) > byte_idx_q)    buf_q[i] <= 8'h00;
                end
                // later assignment overrides the zero fill above
                if (len_pend_q || len_fits) begin
                    for (int j = 0; j < 8; j++)
                        buf_q[56 + j] <= bitlen_q[63 - 8*j -: 8];
                end
                pad_pend_q <= 1'b0;
                if (len_pend_q) begin
                    len_pend_q <= 1'b0;
                    final_q    <= 1'b1;
                end else if (len_fits) begin
                    final_q    <= 1'b1;
                end else begin
                    len_pend_q <= 1'b1;
                end
            end

            if (load_en) begin
                for (int i = 0; i < 8; i++) wv_q[i] <= h_q[i];
                for (int i = 0; i < 16; i++)
                    w_q[i] <= {buf_q[4*i], buf_q[4*i+1], buf_q[4*i+2], buf_q[4*i+3]};
                round_q <= 6'd0;
            end

            if (round_en) begin
                wv_q[7] <= wv_q[6];
                wv_q[6] <= wv_q[5];
                wv_q[5] <= wv_q[4];
                wv_q[4] <= wv_q[3] + t1;
                wv_q[3] <= wv_q[2];
                wv_q[2] <= wv_q[1];
                wv_q[1] <= wv_q[0];
                wv_q[0] <= t1 + t2;
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= w_nx;
                round_q <= round_q + 6'd1;
            end

            if (upd_en) begin
                for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
                if (final_q) begin
                    hash_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                               h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign hash_out = hash_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
module tb_sha256_stream_core;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         rst, start, data_valid, data_last;
    logic [7:0]   data_in;
    logic [255:0] hash_out;
    logic         done;

    int n_chk = 0;
    int n_err = 0;

    sha256_stream_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .hash_out   (hash_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    localparam logic [31:0] RK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] RIV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input bq_t m);
        bq_t         p;
        logic [63:0] len;
        logic [31:0] h [8];
        logic [31:0] v [8];
        logic [31:0] w [64];
        logic [31:0] tt1, tt2;
        p   = m;
        len = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 7; j >= 0; j--) p.push_back(len[8*j +: 8]);
        for (int i = 0; i < 8; i++) h[i] = RIV[i];
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[64*b+4*t], p[64*b+4*t+1], p[64*b+4*t+2], p[64*b+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            for (int i = 0; i < 8; i++) v[i] = h[i];
            for (int t = 0; t < 64; t++) begin
                tt1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                    + ((v[4] & v[5]) ^ (~v[4] & v[6])) + RK[t] + w[t];
                tt2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                    + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + tt1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = tt1 + tt2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse (with a junk byte that must be dropped), then bytes every
    // other cycle; block-completing bytes are followed by a 72-cycle gap
    // carrying one junk byte while the core is busy compressing
    task automatic send(input bq_t m);
        start = 1'b1; data_valid = 1'b1; data_in = 8'hEE;
        tick();
        start = 1'b0; data_valid = 1'b0;
        chk("done_clr_after_start", {255'h0, done}, 256'h0);
        for (int i = 0; i < m.size(); i++) begin
            data_in = m[i]; data_valid = 1'b1; data_last = (i == m.size() - 1);
            tick();
            data_valid = 1'b0; data_last = 1'b0;
            if (i == m.size() - 1) break;
            if (i % 64 == 63) begin
                repeat (10) tick();
                data_in = 8'($urandom); data_valid = 1'b1;
                tick();
                data_valid = 1'b0;
                repeat (61) tick();
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_done"}, {255'h0, done}, 256'h1);
        chk({tag, "_latency_le_140"}, {255'h0, (lat <= 140)}, 256'h1);
    endtask

    task automatic run_vec(input string tag, input bq_t m, input logic [255:0] exp);
        send(m);
        wait_done(tag);
        chk(tag, hash_out, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bq_t          m;
        logic [255:0] held;
        int           lens [13];

        rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00;
        repeat (4) tick();
        chk("reset_done", {255'h0, done}, 256'h0);
        chk("reset_hash", hash_out, 256'h0);
        rst = 1'b0;
        tick();

        m = {};
        repeat (64) m.push_back(8'h61);
        run_vec("a64", m, 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb);

        held = hash_out;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_done", {255'h0, done}, 256'h1);
            chk("hold_hash", hash_out, held);
        end

        run_vec("abc", s2q("abc"), 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        run_vec("a1", s2q("a"), 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb);
        run_vec("abc56", s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"),
                256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        lens = '{1, 55, 56, 63, 64, 65, 119, 120, 127, 128, 0, 0, 0};
        for (int k = 10; k < 13; k++) lens[k] = int'($urandom_range(1, 200));
        for (int k = 0; k < 13; k++) begin
            m = {};
            repeat (lens[k]) m.push_back(8'($urandom));
            run_vec($sformatf("rand_len%0d", lens[k]), m, sha_ref(m));
        end

        // abort part-way through a block
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            data_in = 8'($urandom); data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_done", {255'h0, done}, 256'h0);
        chk("midrst_hash", hash_out, 256'h0);
        tick();
        run_vec("abc_after_rst", s2q("abc"), 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
